id_stage: RTL and testbench

- Instruction-decode stage directly downstream of instruction fetch.
- Owns the IF/ID pipeline register, the 32x32 register file, branch/jump resolution and hazard detection.
- Drives the fetch stage's stall, next-PC select and jump target.
- Presents a registered ID/EX bundle to execute.
- PC is word-addressed (increment by 1); there is no branch delay slot.

---
 rtl/id_stage_pkg.sv | 48 ++++
 rtl/id_stage_if.sv | 45 ++++
 rtl/id_stage_register_file.sv | 39 +++
 rtl/id_stage.sv | 120 ++++++++++++
 tb/tb_id_stage.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/id_stage_pkg.sv
// Shared decode constants and pipeline-register bundles for the instruction-decode stage.
package id_stage_pkg;

   localparam int SIZE      = 32;
   localparam int REG_COUNT = 32;
   localparam int REG_AW    = 5;

   localparam logic [REG_AW-1:0] LINK_REG = 5'd31;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_JR    = 6'b001000;
   localparam logic [5:0] FN_JALR  = 6'b001001;

   localparam logic [SIZE-1:0] NOP = '0;

   typedef struct packed {
      logic [SIZE-1:0] instr;
      logic [SIZE-1:0] pc_plus1;
      logic            valid;
   } ifid_t;

   typedef struct packed {
      logic              valid;
      logic [SIZE-1:0]   rs_data;
      logic [SIZE-1:0]   rt_data;
      logic [SIZE-1:0]   imm_ext;
      logic [SIZE-1:0]   pc_plus1;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic [REG_AW-1:0] rd;
      logic [5:0]        opcode;
      logic [5:0]        funct;
      logic              link;
   } idex_t;

   function automatic logic [SIZE-1:0] sext16(input logic [15:0] imm);
      return {{(SIZE-16){imm[15]}}, imm};
   endfunction

endpackage

// File: rtl/id_stage_if.sv
// Fetch/writeback/hazard inputs and ID/EX outputs of the decode stage; slave = decode, master = surroundings.
interface id_stage_if;
   import id_stage_pkg::*;

   logic [SIZE-1:0]   i_instruction;
   logic [SIZE-1:0]   i_pc_plus1;
   logic              i_wb_en;
   logic [REG_AW-1:0] i_wb_addr;
   logic [SIZE-1:0]   i_wb_data;
   logic              i_ex_reg_write;
   logic              i_ex_mem_read;
   logic [REG_AW-1:0] i_ex_rd;
   logic              i_mem_reg_write;
   logic [REG_AW-1:0] i_mem_rd;

   logic              o_stall;
   logic              o_jump_taken;
   logic [SIZE-1:0]   o_jump_target;
   logic              o_valid;
   logic [SIZE-1:0]   o_rs_data;
   logic [SIZE-1:0]   o_rt_data;
   logic [SIZE-1:0]   o_imm_ext;
   logic [REG_AW-1:0] o_rs;
   logic [REG_AW-1:0] o_rt;
   logic [REG_AW-1:0] o_rd;
   logic [5:0]        o_opcode;
   logic [5:0]        o_funct;
   logic [SIZE-1:0]   o_pc_plus1;
   logic              o_link;

   modport slave (
      input  i_instruction, i_pc_plus1, i_wb_en, i_wb_addr, i_wb_data,
             i_ex_reg_write, i_ex_mem_read, i_ex_rd, i_mem_reg_write, i_mem_rd,
      output o_stall, o_jump_taken, o_jump_target, o_valid, o_rs_data, o_rt_data,
             o_imm_ext, o_rs, o_rt, o_rd, o_opcode, o_funct, o_pc_plus1, o_link
   );

   modport master (
      output i_instruction, i_pc_plus1, i_wb_en, i_wb_addr, i_wb_data,
             i_ex_reg_write, i_ex_mem_read, i_ex_rd, i_mem_reg_write, i_mem_rd,
      input  o_stall, o_jump_taken, o_jump_target, o_valid, o_rs_data, o_rt_data,
             o_imm_ext, o_rs, o_rt, o_rd, o_opcode, o_funct, o_pc_plus1, o_link
   );

endinterface

// File: rtl/id_stage_register_file.sv
// 2-read/1-write register file, R0 hard-wired to zero; reads are combinational.
// A same-cycle write to the read address is bypassed to the read port.
module id_stage_register_file
   import id_stage_pkg::*;
#(
   parameter int WIDTH = SIZE,
   parameter int DEPTH = REG_COUNT,
   parameter int AW    = REG_AW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [AW-1:0]    rd_addr_a,
   output logic [WIDTH-1:0] rd_data_a,
   input  logic [AW-1:0]    rd_addr_b,
   output logic [WIDTH-1:0] rd_data_b,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data
);

   logic [WIDTH-1:0] regs [DEPTH];
   logic             wr_live;

   assign wr_live = wr_en && (wr_addr != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else if (wr_live) begin
         regs[wr_addr] <= wr_data;
      end
   end

   assign rd_data_a = (rd_addr_a == '0)                 ? '0      :
                      (wr_live && wr_addr == rd_addr_a) ? wr_data : regs[rd_addr_a];
   assign rd_data_b = (rd_addr_b == '0)                 ? '0      :
                      (wr_live && wr_addr == rd_addr_b) ? wr_data : regs[rd_addr_b];

endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID register, register file, branch/jump resolution and hazard stall to fetch.
// ID/EX outputs appear one posedge after an instruction sits in IF/ID; a stall holds IF/ID and bubbles ID/EX.
module id_stage
   import id_stage_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   id_stage_if.slave bus
);

   ifid_t ifid;
   idex_t idex, idex_next;

   logic [5:0]        opcode, funct;
   logic [REG_AW-1:0] rs, rt, rd;
   logic [SIZE-1:0]   imm_ext, rs_val, rt_val, jump_tgt;
   logic              is_beq, is_bne, is_j, is_jal, is_jr, is_jalr, is_branch, rt_used;
   logic              load_use, ex_hit, mem_hit, jump_dep, stall, jump_cond, jump_taken;

   assign opcode  = ifid.instr[31:26];
   assign rs      = ifid.instr[25:21];
   assign rt      = ifid.instr[20:16];
   assign rd      = ifid.instr[15:11];
   assign funct   = ifid.instr[5:0];
   assign imm_ext = sext16(ifid.instr[15:0]);

   id_stage_register_file u_rf (
      .clk       (clk),
      .rst       (rst),
      .rd_addr_a (rs),
      .rd_data_a (rs_val),
      .rd_addr_b (rt),
      .rd_data_b (rt_val),
      .wr_en     (bus.i_wb_en),
      .wr_addr   (bus.i_wb_addr),
      .wr_data   (bus.i_wb_data)
   );

   assign is_beq    = (opcode == OP_BEQ);
   assign is_bne    = (opcode == OP_BNE);
   assign is_j      = (opcode == OP_J);
   assign is_jal    = (opcode == OP_JAL);
   assign is_jr     = (opcode == OP_RTYPE) && (funct == FN_JR);
   assign is_jalr   = (opcode == OP_RTYPE) && (funct == FN_JALR);
   assign is_branch = is_beq || is_bne;
   // rt is a source only for R-type, compares and stores; otherwise it names a destination
   assign rt_used   = (opcode == OP_RTYPE) || is_branch || (opcode == OP_SW);

   assign load_use = bus.i_ex_mem_read && (bus.i_ex_rd != '0) &&
                     ((bus.i_ex_rd == rs) || (rt_used && bus.i_ex_rd == rt));
   assign ex_hit   = bus.i_ex_reg_write && (bus.i_ex_rd != '0) &&
                     ((bus.i_ex_rd == rs) || (is_branch && bus.i_ex_rd == rt));
   assign mem_hit  = bus.i_mem_reg_write && (bus.i_mem_rd != '0) &&
                     ((bus.i_mem_rd == rs) || (is_branch && bus.i_mem_rd == rt));
   // jumps resolve here without forwarding, so they wait until the producer reaches writeback
   assign jump_dep = (is_branch || is_jr || is_jalr) && (ex_hit || mem_hit);
   assign stall    = ifid.valid && (load_use || jump_dep);

   always_comb begin
      jump_cond = 1'b0;
      jump_tgt  = '0;
      if (is_branch) begin
         jump_cond = is_beq ? (rs_val == rt_val) : (rs_val != rt_val);
         jump_tgt  = ifid.pc_plus1 + imm_ext;
      end else if (is_j || is_jal) begin
         jump_cond = 1'b1;
         jump_tgt  = {ifid.pc_plus1[SIZE-1:26], ifid.instr[25:0]};
      end else if (is_jr || is_jalr) begin
         jump_cond = 1'b1;
         jump_tgt  = rs_val;
      end
   end

   assign jump_taken        = ifid.valid && jump_cond && !stall;
   assign bus.o_stall       = stall;
   assign bus.o_jump_taken  = jump_taken;
   assign bus.o_jump_target = jump_taken ? jump_tgt : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         ifid <= '0;
      end else if (!stall) begin
         if (jump_taken) ifid <= '0;
         else            ifid <= '{instr: bus.i_instruction, pc_plus1: bus.i_pc_plus1, valid: 1'b1};
      end
   end

   always_comb begin
      idex_next          = '0;
      idex_next.valid    = 1'b1;
      idex_next.rs_data  = rs_val;
      idex_next.rt_data  = rt_val;
      idex_next.imm_ext  = imm_ext;
      idex_next.pc_plus1 = ifid.pc_plus1;
      idex_next.rs       = rs;
      idex_next.rt       = rt;
      idex_next.rd       = is_jal ? LINK_REG : rd;
      idex_next.opcode   = opcode;
      idex_next.funct    = funct;
      idex_next.link     = is_jal || is_jalr;
   end

   always_ff @(posedge clk) begin
      if (rst || stall || !ifid.valid) idex <= '0;
      else                             idex <= idex_next;
   end

   assign bus.o_valid    = idex.valid;
   assign bus.o_rs_data  = idex.rs_data;
   assign bus.o_rt_data  = idex.rt_data;
   assign bus.o_imm_ext  = idex.imm_ext;
   assign bus.o_rs       = idex.rs;
   assign bus.o_rt       = idex.rt;
   assign bus.o_rd       = idex.rd;
   assign bus.o_opcode   = idex.opcode;
   assign bus.o_funct    = idex.funct;
   assign bus.o_pc_plus1 = idex.pc_plus1;
   assign bus.o_link     = idex.link;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode, bypass, branches/jumps, load-use and branch-dependency stalls, reset.
module tb_id_stage;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   id_stage_if bus ();

   id_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'b000000, rs, rt, rd, 5'd0, fn};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [31:0] instr, input logic [31:0] pc1);
      bus.i_instruction = instr;
      bus.i_pc_plus1    = pc1;
   endtask

   task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
      bus.i_wb_en   = en;
      bus.i_wb_addr = a;
      bus.i_wb_data = d;
   endtask

   task automatic ex(input logic rw, input logic mr, input logic [4:0] r);
      bus.i_ex_reg_write = rw;
      bus.i_ex_mem_read  = mr;
      bus.i_ex_rd        = r;
   endtask

   task automatic mem(input logic rw, input logic [4:0] r);
      bus.i_mem_reg_write = rw;
      bus.i_mem_rd        = r;
   endtask

   task automatic rf_zero(input string tag);
      logic [31:0] acc;
      acc = '0;
      for (int i = 0; i < 32; i++) acc = acc | dut.u_rf.regs[i];
      chk(tag, acc, 32'h0);
   endtask

   logic [31:0] nop, junk;

   initial begin
      nop  = 32'h0;
      junk = enc_i(6'h0f, 5'd0, 5'd2, 16'd9);
      fetch(nop, 32'd0);
      wb(1'b0, 5'd0, 32'd0);
      ex(1'b0, 1'b0, 5'd0);
      mem(1'b0, 5'd0);

      tick();
      tick();
      chk("rst_valid", bus.o_valid, 1'b0);
      chk("rst_opcode", bus.o_opcode, 6'd0);
      chk("rst_rs_data", bus.o_rs_data, 32'd0);
      chk("rst_stall", bus.o_stall, 1'b0);
      chk("rst_jump", bus.o_jump_taken, 1'b0);
      rf_zero("rst_rf");

      // LUI R1,7
      rst = 1'b0;
      fetch(enc_i(6'h0f, 5'd0, 5'd1, 16'd7), 32'd1);
      tick();
      fetch(nop, 32'd2);
      tick();
      chk("lui_valid", bus.o_valid, 1'b1);
      chk("lui_opcode", bus.o_opcode, 6'h0f);
      chk("lui_rt", bus.o_rt, 5'd1);
      chk("lui_imm", bus.o_imm_ext, 32'd7);
      chk("lui_link", bus.o_link, 1'b0);

      // writeback bypass into R9, then R0 write is ignored
      fetch(enc_r(5'd9, 5'd0, 5'd10, 6'h21), 32'd3);
      tick();
      wb(1'b1, 5'd9, 32'h55);
      fetch(enc_r(5'd0, 5'd9, 5'd11, 6'h21), 32'd4);
      tick();
      chk("byp_rs_data", bus.o_rs_data, 32'h55);
      chk("byp_rd", bus.o_rd, 5'd10);
      chk("byp_funct", bus.o_funct, 6'h21);
      wb(1'b1, 5'd0, 32'hDEAD);
      fetch(nop, 32'd5);
      tick();
      chk("r0_rs_data", bus.o_rs_data, 32'd0);
      chk("r9_stored", bus.o_rt_data, 32'h55);
      wb(1'b1, 5'd1, 32'd3);
      tick();
      wb(1'b1, 5'd3, 32'd3);
      tick();

      // BEQ R1,R3,+1 at pc_plus1 = 4, taken; wrong-path LUI squashed
      wb(1'b0, 5'd0, 32'd0);
      fetch(enc_i(6'h04, 5'd1, 5'd3, 16'd1), 32'd4);
      tick();
      fetch(junk, 32'd5);
      #1;
      chk("beq_taken", bus.o_jump_taken, 1'b1);
      chk("beq_target", bus.o_jump_target, 32'd5);
      chk("beq_stall", bus.o_stall, 1'b0);
      tick();
      chk("beq_idex_valid", bus.o_valid, 1'b1);
      chk("beq_idex_opcode", bus.o_opcode, 6'h04);
      chk("squash_jump", bus.o_jump_taken, 1'b0);
      fetch(nop, 32'd6);
      tick();
      chk("squash_valid", bus.o_valid, 1'b0);
      chk("squash_rt", bus.o_rt, 5'd0);

      // JALR R9,R1 with R1 = 7
      wb(1'b1, 5'd1, 32'd7);
      fetch(enc_r(5'd1, 5'd0, 5'd9, 6'h09), 32'd5);
      tick();
      wb(1'b0, 5'd0, 32'd0);
      fetch(nop, 32'd6);
      #1;
      chk("jalr_taken", bus.o_jump_taken, 1'b1);
      chk("jalr_target", bus.o_jump_target, 32'd7);
      tick();
      chk("jalr_link", bus.o_link, 1'b1);
      chk("jalr_rd", bus.o_rd, 5'd9);
      chk("jalr_pc1", bus.o_pc_plus1, 32'd5);
      chk("jalr_rs_data", bus.o_rs_data, 32'd7);

      // JAL keeps the upper PC bits and links to R31
      fetch({6'h03, 26'h0000123}, 32'h1000_0010);
      tick();
      fetch(nop, 32'h1000_0011);
      #1;
      chk("jal_taken", bus.o_jump_taken, 1'b1);
      chk("jal_target", bus.o_jump_target, 32'h1000_0123);
      tick();
      chk("jal_rd", bus.o_rd, 5'd31);
      chk("jal_link", bus.o_link, 1'b1);

      // load-use: EX loads R5, decode ADDU R7,R5,R3
      fetch(enc_r(5'd5, 5'd3, 5'd7, 6'h21), 32'd20);
      tick();
      ex(1'b1, 1'b1, 5'd5);
      fetch(junk, 32'd21);
      #1;
      chk("lu_stall", bus.o_stall, 1'b1);
      tick();
      chk("lu_bubble", bus.o_valid, 1'b0);
      ex(1'b0, 1'b0, 5'd0);
      mem(1'b1, 5'd5);
      wb(1'b1, 5'd5, 32'h1234);
      #1;
      chk("lu_release", bus.o_stall, 1'b0);
      tick();
      chk("lu_valid", bus.o_valid, 1'b1);
      chk("lu_rd", bus.o_rd, 5'd7);
      chk("lu_pc1_held", bus.o_pc_plus1, 32'd20);
      chk("lu_rs_data", bus.o_rs_data, 32'h1234);
      chk("lu_rt_data", bus.o_rt_data, 32'd3);

      // BNE R1,R3,-2 with R1 produced in EX: stale R1 = 7 would be taken
      mem(1'b0, 5'd0);
      wb(1'b0, 5'd0, 32'd0);
      fetch(enc_i(6'h05, 5'd1, 5'd3, 16'hFFFE), 32'd40);
      tick();
      ex(1'b1, 1'b0, 5'd1);
      fetch(junk, 32'd41);
      #1;
      chk("bne_stall_ex", bus.o_stall, 1'b1);
      chk("bne_jump_ex", bus.o_jump_taken, 1'b0);
      tick();
      chk("bne_bubble", bus.o_valid, 1'b0);
      ex(1'b0, 1'b0, 5'd0);
      mem(1'b1, 5'd1);
      #1;
      chk("bne_stall_mem", bus.o_stall, 1'b1);
      chk("bne_jump_mem", bus.o_jump_taken, 1'b0);
      tick();
      mem(1'b0, 5'd0);
      wb(1'b1, 5'd1, 32'd3);
      #1;
      chk("bne_stall_wb", bus.o_stall, 1'b0);
      chk("bne_jump_wb", bus.o_jump_taken, 1'b0);
      tick();
      wb(1'b0, 5'd0, 32'd0);
      chk("bne_valid", bus.o_valid, 1'b1);
      chk("bne_imm", bus.o_imm_ext, 32'hFFFF_FFFE);
      chk("bne_rs_data", bus.o_rs_data, 32'd3);
      chk("bne_pc1", bus.o_pc_plus1, 32'd40);

      // BNE R1,R0,-2 at pc_plus1 = 50, taken backwards
      fetch(enc_i(6'h05, 5'd1, 5'd0, 16'hFFFE), 32'd50);
      tick();
      fetch(nop, 32'd51);
      #1;
      chk("bne2_taken", bus.o_jump_taken, 1'b1);
      chk("bne2_target", bus.o_jump_target, 32'd48);

      // reset mid-operation
      rst = 1'b1;
      tick();
      chk("mr_valid", bus.o_valid, 1'b0);
      chk("mr_pc1", bus.o_pc_plus1, 32'd0);
      chk("mr_jump", bus.o_jump_taken, 1'b0);
      rf_zero("mr_rf");
      rst = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
